// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one FPU among NUM_REQ requesters; each op is launched by an FPU reset pulse.
// Optional macro FPU_ZERO_BYPASS_EN answers ops with a zero operand directly, without touching the FPU.
module fpu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int FPU_LAT = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clock_100Khz,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_op_a,
    input  logic [32*NUM_REQ-1:0]  req_op_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_data,
    output logic [3:0]             rsp_status,
    output logic                   busy,
    output logic                   fpu_rst_n,
    output logic [31:0]            fpu_op_a,
    output logic [31:0]            fpu_op_b,
    input  logic [31:0]            fpu_data_in,
    input  logic [3:0]             fpu_status_in
);
    localparam int CW = $clog2(FPU_LAT + 1);

    if (FPU_LAT < 1 || NUM_REQ < 2 || NUM_REQ > 8) begin : g_param_check
        $error("fpu_arbiter: FPU_LAT must be >= 1 and NUM_REQ must be in 2..8");
    end

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, RESPOND} state_t;

    state_t            state, state_nx;
    logic [ID_W-1:0]   rr_ptr, rr_nx, gnt, idx, id_nx;
    logic              gnt_any, valid_nx, frst_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [NUM_REQ-1:0] ready_nx;
    logic [31:0]       data_nx, op_a_nx, op_b_nx, sel_a, sel_b;
    logic [3:0]        status_nx;

`ifdef FPU_ZERO_BYPASS_EN
    logic        byp, byp_nx, a_zero, b_zero;
    logic [31:0] byp_data, byp_data_nx;
    assign a_zero = sel_a[30:0] == '0;
    assign b_zero = sel_b[30:0] == '0;
`endif

    // Cyclic search from rr_ptr; scanning downward leaves the nearest pending requester in gnt.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        gnt_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((32'(rr_ptr) + 32'(i)) % 32'(NUM_REQ));
            if (req_valid[idx]) begin
                gnt     = idx;
                gnt_any = 1'b1;
            end
        end
    end

    assign sel_a = req_op_a[{gnt, 5'b0} +: 32];
    assign sel_b = req_op_b[{gnt, 5'b0} +: 32];

    always_comb begin
        state_nx  = state;
        rr_nx     = rr_ptr;
        cnt_nx    = cnt;
        ready_nx  = '0;
        valid_nx  = rsp_valid;
        id_nx     = rsp_id;
        data_nx   = rsp_data;
        status_nx = rsp_status;
        op_a_nx   = fpu_op_a;
        op_b_nx   = fpu_op_b;
        frst_nx   = 1'b1;
`ifdef FPU_ZERO_BYPASS_EN
        byp_nx      = byp;
        byp_data_nx = byp_data;
`endif
        case (state)
            IDLE: if (gnt_any) begin
                ready_nx[gnt] = 1'b1;
                id_nx         = gnt;
                op_a_nx       = sel_a;
                op_b_nx       = sel_b;
                frst_nx       = 1'b0;
                state_nx      = LAUNCH;
`ifdef FPU_ZERO_BYPASS_EN
                byp_nx      = a_zero || b_zero;
                byp_data_nx = a_zero ? (b_zero ? '0 : sel_b) : sel_a;
                if (a_zero || b_zero) begin
                    op_a_nx  = fpu_op_a;
                    op_b_nx  = fpu_op_b;
                    frst_nx  = 1'b1;
                    state_nx = CAPTURE;
                end
`endif
            end
            LAUNCH: begin
                cnt_nx   = CW'(FPU_LAT - 1);
                state_nx = WAIT;
            end
            WAIT: begin
                cnt_nx   = cnt == '0 ? cnt : cnt - 1'b1;
                state_nx = cnt == '0 ? CAPTURE : WAIT;
            end
            CAPTURE: begin
                data_nx   = fpu_data_in;
                status_nx = fpu_status_in;
                valid_nx  = 1'b1;
                state_nx  = RESPOND;
`ifdef FPU_ZERO_BYPASS_EN
                if (byp) begin
                    data_nx   = byp_data;
                    status_nx = '0;
                end
`endif
            end
            RESPOND: if (rsp_ready) begin
                valid_nx = 1'b0;
                rr_nx    = rsp_id == ID_W'(NUM_REQ - 1) ? '0 : rsp_id + 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            req_ready  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_status <= '0;
            fpu_op_a   <= '0;
            fpu_op_b   <= '0;
            fpu_rst_n  <= 1'b0;
            busy       <= 1'b0;
`ifdef FPU_ZERO_BYPASS_EN
            byp        <= 1'b0;
            byp_data   <= '0;
`endif
        end else begin
            state      <= state_nx;
            rr_ptr     <= rr_nx;
            cnt        <= cnt_nx;
            req_ready  <= ready_nx;
            rsp_valid  <= valid_nx;
            rsp_id     <= id_nx;
            rsp_data   <= data_nx;
            rsp_status <= status_nx;
            fpu_op_a   <= op_a_nx;
            fpu_op_b   <= op_b_nx;
            fpu_rst_n  <= frst_nx;
            busy       <= state_nx != IDLE;
`ifdef FPU_ZERO_BYPASS_EN
            byp        <= byp_nx;
            byp_data   <= byp_data_nx;
`endif
        end
    end
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed and randomized bench for fpu_arbiter, checked against a transaction-level model
// and driving a stub FPU that only produces its result some cycles after its reset pulse.
module tb_fpu_arbiter;
    localparam int NR       = 4;
    localparam int LAT      = 32;
    localparam int IW       = 2;
    localparam int STUB_DLY = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [32*NR-1:0] req_op_a = '0;
    logic [32*NR-1:0] req_op_b = '0;
    logic [NR-1:0]    req_ready;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IW-1:0]    rsp_id;
    logic [31:0]      rsp_data;
    logic [3:0]       rsp_status;
    logic             busy, fpu_rst_n;
    logic [31:0]      fpu_op_a, fpu_op_b, fpu_data_in;
    logic [3:0]       fpu_status_in;
    int               total = 0;
    int               bad = 0;

    always #5 clk = ~clk;

    fpu_arbiter #(.NUM_REQ(NR), .FPU_LAT(LAT)) dut (
        .clock_100Khz(clk), .reset(reset), .req_valid(req_valid), .req_op_a(req_op_a),
        .req_op_b(req_op_b), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_status(rsp_status), .busy(busy),
        .fpu_rst_n(fpu_rst_n), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
        .fpu_data_in(fpu_data_in), .fpu_status_in(fpu_status_in)
    );

    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b);
        return (a == 32'h3FE00000 && b == 32'h3FE00000) ? 32'h40000000 : a + {b[15:0], b[31:16]};
    endfunction

    function automatic logic [3:0] fpu_st(input logic [31:0] a, input logic [31:0] b);
        return {2'b00, a[1:0] ^ b[1:0]};
    endfunction

    // Stub FPU: garbage while in reset, correct result only STUB_DLY cycles after reset release.
    int unsigned stub_cnt;
    always_ff @(posedge clk) begin
        if (!fpu_rst_n) begin
            stub_cnt      <= 0;
            fpu_data_in   <= 32'hDEADBEEF;
            fpu_status_in <= 4'hF;
        end else if (stub_cnt < STUB_DLY) begin
            stub_cnt <= stub_cnt + 1;
        end else begin
            fpu_data_in   <= fpu_fn(fpu_op_a, fpu_op_b);
            fpu_status_in <= fpu_st(fpu_op_a, fpu_op_b);
        end
    end

    bit            m_busy, m_vld, m_byp;
    int            m_age, m_rr;
    logic [IW-1:0] m_id;
    logic [31:0]   m_res, m_data, m_opa, m_opb;
    logic [3:0]    m_rst, m_stat;
    bit [NR-1:0]   persist;
    int            ncyc, rst_lows;
    int            glog[$];
    int            rlog[$];
    logic          prev_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        return ($urandom_range(0, 7) == 0) ? ($urandom & 32'h80000000) : $urandom;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]          = 1'b1;
        req_op_a[32*i +: 32]  = a;
        req_op_b[32*i +: 32]  = b;
    endtask

    // Transaction view: a request is granted when the server is free, answered LAT+2 edges later
    // (1 edge when bypassed), and the server frees on the handshake edge.
    task automatic model_edge();
        logic [31:0]   ga, gb;
        logic [IW-1:0] j;
        int            g;
        g = -1;
        if (!m_busy) begin
            for (int k = 0; k < NR; k++) begin
                j = IW'((m_rr + k) % NR);
                if (g < 0 && req_valid[j]) g = int'(j);
            end
            if (g >= 0) begin
                ga     = req_op_a[32*g +: 32];
                gb     = req_op_b[32*g +: 32];
                m_busy = 1'b1;
                m_age  = 0;
                m_id   = IW'(g);
                m_byp  = 1'b0;
                m_res  = fpu_fn(ga, gb);
                m_rst  = fpu_st(ga, gb);
`ifdef FPU_ZERO_BYPASS_EN
                if (ga[30:0] == 0 || gb[30:0] == 0) begin
                    m_byp = 1'b1;
                    m_res = (ga[30:0] == 0) ? ((gb[30:0] == 0) ? 32'h0 : gb) : ga;
                    m_rst = 4'h0;
                end
`endif
                if (!m_byp) begin
                    m_opa = ga;
                    m_opb = gb;
                end
            end
        end else if (m_vld && rsp_ready) begin
            m_vld  = 1'b0;
            m_busy = 1'b0;
            m_rr   = (int'(m_id) + 1) % NR;
        end else begin
            m_age++;
            if (m_age == (m_byp ? 1 : LAT + 2)) begin
                m_vld  = 1'b1;
                m_data = m_res;
                m_stat = m_rst;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NR-1:0] er;
        er = '0;
        if (m_busy && m_age == 0) er[m_id] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("ctrl{valid,busy,fpu_rst_n}", {28'b0, rsp_valid, busy, fpu_rst_n, 1'b0},
            {28'b0, m_vld, m_busy, !(m_busy && m_age == 0 && !m_byp), 1'b0});
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_id_status", {26'b0, rsp_id, rsp_status}, {26'b0, m_id, m_stat});
        chk("fpu_op_a", fpu_op_a, m_opa);
        chk("fpu_op_b", fpu_op_b, m_opb);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        ncyc++;
        model_edge();
        check_outputs();
        if (fpu_rst_n === 1'b0) rst_lows++;
        if (rsp_valid && !prev_vld) rlog.push_back(ncyc);
        prev_vld = rsp_valid;
        for (int i = 0; i < NR; i++)
            if (req_ready[i]) begin
                glog.push_back(i);
                if (persist[i]) set_req(i, $urandom | 32'h1, $urandom | 32'h1);
                else req_valid[i] = 1'b0;
            end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        persist   = '0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_ctrl", {28'b0, rsp_valid, busy, fpu_rst_n, 1'b0}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_id_status", {26'b0, rsp_id, rsp_status}, 0);
        chk("rst_fpu_ops", fpu_op_a | fpu_op_b, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        m_busy = 0; m_vld = 0; m_byp = 0; m_age = 0; m_rr = 0; m_id = '0;
        m_res = '0; m_data = '0; m_opa = '0; m_opb = '0; m_rst = '0; m_stat = '0;
        prev_vld = 1'b0;
        rst_lows = 0;
        glog.delete();
        rlog.delete();
    endtask

    initial begin
        int n;
        #2;
        do_reset();
        // single op, latency and FPU launch pulse
        rsp_ready = 1'b1;
        set_req(0, 32'h3FE00000, 32'h3FE00000);
        n = 0;
        do begin cyc(); n++; end while (!rsp_valid && n < 200);
        chk("t1_latency", 32'(n), LAT + 3);
        chk("t1_fpu_rst_lows", 32'(rst_lows), 1);
        chk("t1_rsp_data", rsp_data, 32'h40000000);
        chk("t1_id_status", 32'({rsp_id, rsp_status}), 0);
        chk("t1_grants", 32'(glog.size()), 1);
        cyc();
        // all four at once: order 0..3, responses 36 cycles apart
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, $urandom | 32'h1, $urandom | 32'h1);
        n = 0;
        while ((glog.size() < NR || busy) && n < 400) begin cyc(); n++; end
        chk("t2_grants", 32'(glog.size()), NR);
        for (int k = 0; k < glog.size(); k++) chk("t2_order", 32'(glog[k]), 32'(k));
        chk("t2_responses", 32'(rlog.size()), NR);
        for (int k = 1; k < rlog.size(); k++) chk("t2_spacing", 32'(rlog[k] - rlog[k-1]), LAT + 4);
        // backpressure with requester 1 waiting
        do_reset();
        set_req(0, 32'h12345677, 32'h0000F001);
        cyc();
        set_req(1, 32'h3F000003, 32'h41000005);
        n = 0;
        while (!rsp_valid && n < 200) begin cyc(); n++; end
        repeat (10) cyc();
        chk("t3_stall_grants", 32'(glog.size()), 1);
        chk("t3_stall_valid", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        cyc();
        cyc();
        chk("t3_grant1", 32'(req_ready), 32'b0010);
        n = 0;
        while (busy && n < 200) begin cyc(); n++; end
        // fairness wrap: 3, then 0, then 3 with 4'b1001 held
        do_reset();
        rsp_ready = 1'b1;
        set_req(3, 32'h00000011, 32'h00000022);
        cyc();
        persist = 4'b1001;
        set_req(0, 32'h00000101, 32'h00000202);
        set_req(3, 32'h00000303, 32'h00000404);
        n = 0;
        while (glog.size() < 3 && n < 300) begin cyc(); n++; end
        chk("t4_grants", 32'(glog.size()), 3);
        if (glog.size() >= 3) begin
            chk("t4_first", 32'(glog[0]), 3);
            chk("t4_wrap", 32'(glog[1]), 0);
            chk("t4_back", 32'(glog[2]), 3);
        end
        persist   = '0;
        req_valid = '0;
        n = 0;
        while (busy && n < 200) begin cyc(); n++; end
        // reset during WAIT, then a clean op
        do_reset();
        rsp_ready = 1'b1;
        set_req(2, 32'h40400001, 32'h40800002);
        repeat (10) cyc();
        chk("t5_busy_before", 32'(busy), 1);
        do_reset();
        rsp_ready = 1'b1;
        repeat (60) cyc();
        chk("t5_no_rsp", 32'(rlog.size()), 0);
        set_req(2, 32'h40400001, 32'h40800002);
        n = 0;
        do begin cyc(); n++; end while (!rsp_valid && n < 200);
        chk("t5_latency", 32'(n), LAT + 3);
        cyc();
        // zero operand
        do_reset();
        rsp_ready = 1'b1;
        set_req(1, 32'h0, 32'h40000000);
        n = 0;
        do begin cyc(); n++; end while (!rsp_valid && n < 200);
`ifdef FPU_ZERO_BYPASS_EN
        chk("t6_latency", 32'(n), 2);
        chk("t6_data", rsp_data, 32'h40000000);
        chk("t6_fpu_rst_lows", 32'(rst_lows), 0);
`else
        chk("t6_latency", 32'(n), LAT + 3);
        chk("t6_data", rsp_data, 32'h00004000);
        chk("t6_fpu_rst_lows", 32'(rst_lows), 1);
`endif
        chk("t6_status", 32'(rsp_status), 0);
        cyc();
        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 15) == 0) set_req(i, rnd_op(), rnd_op());
                else if (req_valid[i] && $urandom_range(0, 63) == 0) req_valid[i] = 1'b0;
            end
            persist = NR'($urandom);
            cyc();
        end
        chk("rand_progress", 32'(glog.size() > 20), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
